// File: rtl/mux_share_arbiter.sv
// ---------------------------------------------------------------------------
// mux_share_arbiter
//   Round-robin arbiter that lets NUM_REQ sources share one mux select tree
//   and one output path. The mux select moves only while the output enable
//   is low: every change of owner passes through GUARD_CYC dead cycles
//   followed by one SETUP cycle in which the new select settles. An owner
//   is preempted after MAX_HOLD cycles if any other source is waiting.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req        in   NUM_REQ  level request per source, held while ownership wanted
//   grant      out  NUM_REQ  registered one-hot grant, zero when there is no owner
//   sel        out  SEL_W    registered mux select index
//   outEn      out  1        registered output enable, always equal to |grant
//   busy       out  1        registered, high whenever the arbiter is not IDLE
//   dbg_state  out  2        current FSM state (0 IDLE, 1 SETUP, 2 OWN, 3 GUARD)
//
// Handshake: req is a level; a source owns the path from the cycle its grant
// bit is high until the edge after it drops req (or is preempted). The muxed
// output may be used only while outEn is high.
// ---------------------------------------------------------------------------
module mux_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_W     = 2,
    parameter int MAX_HOLD  = 16,
    parameter int GUARD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               outEn,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int HW = (MAX_HOLD  > 1) ? $clog2(MAX_HOLD)  : 1;
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OWN   = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     rr_ptr;
    logic [HW-1:0]        hold_cnt;
    logic [GW-1:0]        guard_cnt;

    logic [SEL_W-1:0]     winner;
    logic [SEL_W-1:0]     next_ptr;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [2*NUM_REQ-1:0] req_rot;
    logic                 owner_req;
    logic                 others_req;
    logic                 found;
    int                   cand;

    assign dbg_state = state;

    // Rotate req so bit 0 corresponds to rr_ptr, then take the lowest set
    // bit; the rotation handles the wrap-around search.
    always_comb begin
        req_rot = {req, req} >> rr_ptr;
        winner  = rr_ptr;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                winner = SEL_W'(cand);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_onehot = NUM_REQ'(1) << sel;
        owner_req  = |(req & sel_onehot);
        others_req = |(req & ~sel_onehot);
        next_ptr   = (int'(sel) == NUM_REQ - 1) ? '0 : sel + SEL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            outEn     <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            guard_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= winner;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // Ownership starts even if the request vanished during
                    // SETUP; the release check in OWN cleans that up.
                    grant    <= sel_onehot;
                    outEn    <= 1'b1;
                    hold_cnt <= '0;
                    state    <= OWN;
                end
                OWN: begin
                    if (!owner_req || (hold_cnt == HOLD_LAST && others_req)) begin
                        grant     <= '0;
                        outEn     <= 1'b0;
                        rr_ptr    <= next_ptr;
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        guard_cnt <= '0;
                        if (|req) begin
                            sel   <= winner;
                            state <= SETUP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    outEn <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
